osc_param_ctrl: RTL and testbench
=================================

// Module: osc_param_ctrl
// PURPOSE
// - Byte-stream command decoder loading per-oscillator synth parameters (wave, freq, phase, amp).
// - Parametrised successor of the two-oscillator loader: NUM_OSC channels, configurable field widths, clocked with
//   valid strobe, per-channel update strobes, error/timeout reporting.
// - Sits between the host byte interface (UART/SPI RX) and the oscillator bank.
// PARAMETERS
// - NUM_OSC        2     oscillator channels, 1..16 (index = command high nibble)
// - FREQ_BYTES     3     freq payload bytes; FREQ_W = 8*FREQ_BYTES
// - PHASE_BYTES    2     phase payload bytes; PHASE_W = 8*PHASE_BYTES
// - AMP_BYTES      2     amp payload bytes; AMP_W = 8*AMP_BYTES
// - TIMEOUT_CYCLES 1000  max i_clk cycles between payload bytes; 0 disables timeout
// PORTS
// - i_clk         in   1                 system clock, all logic on rising edge
// - i_rst         in   1                 synchronous reset, active high
// - i_data        in   8                 command/payload byte
// - i_data_valid  in   1                 i_data valid this cycle; one byte per high cycle, no backpressure
// - o_busy        out  1                 high whenever state != IDLE
// - o_wave        out  NUM_OSC*8         channel n at [n*8 +: 8]
// - o_freq        out  NUM_OSC*FREQ_W    channel n at [n*FREQ_W +: FREQ_W]
// - o_phase       out  NUM_OSC*PHASE_W   channel n at [n*PHASE_W +: PHASE_W]
// - o_amp         out  NUM_OSC*AMP_W     channel n at [n*AMP_W +: AMP_W]
// - o_update      out  NUM_OSC           1-cycle pulse on bit n when any channel-n register is written
// - o_cmd_err     out  1                 1-cycle pulse: bad command (or checksum mismatch)
// - o_timeout     out  1                 1-cycle pulse: frame aborted by inter-byte timeout
// BEHAVIOUR
// - One clock, synchronous active-high reset. Reset: all o_* registers = 0, state IDLE, counters 0.
// - Reset mid-frame discards partial frame; nothing committed.
// - Frame = command byte + payload bytes, MSB first. cmd[7:4] = channel, cmd[3:0] = field:
//   1 wave (1 byte), 2 freq (FREQ_BYTES), 3 phase (PHASE_BYTES), 4 amp (AMP_BYTES).
// - Channel >= NUM_OSC or field not in 1..4: o_cmd_err pulses cycle after the byte; stay IDLE; byte dropped.
// - States: IDLE -> PAYLOAD (valid good cmd) -> [CHECK if checksum enabled] -> COMMIT -> IDLE.
// - PAYLOAD: shift buffer left 8, insert byte at LSB; byte counter decrements; last byte -> next state.
// - COMMIT lasts exactly one cycle: target field <= buffer (low bits), o_update[ch] pulses same cycle
//   outputs change; latency = 2 edges from edge sampling last byte to o_update high.
// - Byte valid during COMMIT is decoded as a new command (as in IDLE); no byte lost.
// - Other channels/fields untouched by a commit. Rewriting same value still pulses o_update.
// - Timeout (TIMEOUT_CYCLES>0): counter clears on each accepted byte, counts in PAYLOAD/CHECK;
//   reaching TIMEOUT_CYCLES without a byte -> IDLE, o_timeout pulse, no commit.
//   Byte arriving in the cycle the limit is hit wins; no timeout.
// - i_data ignored when i_data_valid low. o_cmd_err and o_timeout never both high.
// CONFIGURATION
// - PARAM_CHECKSUM_EN defined: frame ends with one extra byte = XOR of command and all payload bytes
//   (CHECK state). Match -> COMMIT; mismatch -> IDLE, o_cmd_err pulse, no commit. Timeout applies in CHECK.
// - Not defined: no CHECK state, no checksum byte; COMMIT follows last payload byte.
// TESTING (defaults, PARAM_CHECKSUM_EN undefined unless noted)
// - Reset: after i_rst, all outputs 0, o_busy 0; held i_data_valid during reset has no effect.
// - 0x02,0x12,0x34,0x56 -> o_freq[23:0]=0x123456, o_update=2'b01 one cycle; ch1 freq still 0.
// - 0x13,0xAB,0xCD then 0x11,0x05 back-to-back (cmd in COMMIT cycle) -> ch1 phase 0xABCD, ch1 wave 0x05, two update pulses.
// - 0x25 and 0x07 -> o_cmd_err pulse each, o_busy stays 0, no output change.
// - 0x04,0x80 then 1000 idle cycles -> o_timeout pulse, o_amp unchanged; next 0x01,0x03 -> ch0 wave 0x03.
// - PARAM_CHECKSUM_EN: 0x01,0x07,0x06 -> ch0 wave 0x07; 0x01,0x07,0x00 -> o_cmd_err, wave unchanged.

Source files
------------

// File: rtl/osc_param_ctrl.sv
// Byte-stream command decoder that loads per-oscillator wave/freq/phase/amp registers.
// Optional trailing XOR checksum byte is enabled by defining PARAM_CHECKSUM_EN.
module osc_param_ctrl #(
  parameter int NUM_OSC        = 2,
  parameter int FREQ_BYTES     = 3,
  parameter int PHASE_BYTES    = 2,
  parameter int AMP_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [7:0]                     i_data,
  input  logic                           i_data_valid,
  output logic                           o_busy,
  output logic [NUM_OSC*8-1:0]           o_wave,
  output logic [NUM_OSC*8*FREQ_BYTES-1:0]  o_freq,
  output logic [NUM_OSC*8*PHASE_BYTES-1:0] o_phase,
  output logic [NUM_OSC*8*AMP_BYTES-1:0]   o_amp,
  output logic [NUM_OSC-1:0]             o_update,
  output logic                           o_cmd_err,
  output logic                           o_timeout
);

  localparam int FREQ_W  = 8 * FREQ_BYTES;
  localparam int PHASE_W = 8 * PHASE_BYTES;
  localparam int AMP_W   = 8 * AMP_BYTES;
  localparam int MAX_FP  = (FREQ_W > PHASE_W) ? FREQ_W : PHASE_W;
  localparam int BUF_W   = (MAX_FP > AMP_W) ? MAX_FP : AMP_W;
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int TO_LIM  = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    COMMIT  = 2'd2
`ifdef PARAM_CHECKSUM_EN
    , CHECK = 2'd3
`endif
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          ch;
  logic [2:0]          fld;
  logic [7:0]          cnt;
  logic [BUF_W-1:0]    buffer;
  logic [31:0]         tcnt;
`ifdef PARAM_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  logic                cmd_ok, start_cmd, bad_cmd, load_byte, do_commit, do_timeout;
  logic                waiting, to_hit;
  logic [7:0]          len;
  logic [BUF_W+7:0]    shifted;

  assign o_busy = (state != IDLE);
  assign cmd_ok = ({1'b0, i_data[7:4]} < 5'(NUM_OSC)) && (i_data[3:0] >= 4'd1) && (i_data[3:0] <= 4'd4);
  assign to_hit = TO_EN && (tcnt == 32'(TO_LIM));

  always_comb begin
    state_nxt  = state;
    start_cmd  = 1'b0;
    bad_cmd    = 1'b0;
    load_byte  = 1'b0;
    do_commit  = 1'b0;
    do_timeout = 1'b0;
    waiting    = 1'b0;
    shifted    = {buffer, i_data};
    case (i_data[3:0])
      4'd1:    len = 8'd1;
      4'd2:    len = 8'(FREQ_BYTES);
      4'd3:    len = 8'(PHASE_BYTES);
      4'd4:    len = 8'(AMP_BYTES);
      default: len = 8'd0;
    endcase
    case (state)
      IDLE, COMMIT: begin
        do_commit = (state == COMMIT);
        // A byte arriving in the commit cycle is decoded as a fresh command.
        if (i_data_valid) begin
          if (cmd_ok) begin
            start_cmd = 1'b1;
            state_nxt = PAYLOAD;
          end else begin
            bad_cmd   = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      PAYLOAD: begin
        if (i_data_valid) begin
          load_byte = 1'b1;
          if (cnt == 8'd1) begin
`ifdef PARAM_CHECKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = COMMIT;
`endif
          end else begin
            state_nxt = PAYLOAD;
          end
        end else if (to_hit) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end else begin
          waiting = 1'b1;
        end
      end
`ifdef PARAM_CHECKSUM_EN
      CHECK: begin
        if (i_data_valid) begin
          if (i_data == csum) begin
            state_nxt = COMMIT;
          end else begin
            bad_cmd   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (to_hit) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end else begin
          waiting = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State, frame bookkeeping and registered parameter outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ch        <= 4'd0;
      fld       <= 3'd0;
      cnt       <= 8'd0;
      buffer    <= '0;
      tcnt      <= 32'd0;
`ifdef PARAM_CHECKSUM_EN
      csum      <= 8'd0;
`endif
      o_wave    <= '0;
      o_freq    <= '0;
      o_phase   <= '0;
      o_amp     <= '0;
      o_update  <= '0;
      o_cmd_err <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_update  <= '0;
      o_cmd_err <= bad_cmd;
      o_timeout <= do_timeout;
      tcnt      <= waiting ? tcnt + 32'd1 : 32'd0;
      if (start_cmd) begin
        ch     <= i_data[7:4];
        fld    <= i_data[2:0];
        cnt    <= len;
        buffer <= '0;
`ifdef PARAM_CHECKSUM_EN
        csum   <= i_data;
`endif
      end
      if (load_byte) begin
        buffer <= shifted[BUF_W-1:0];
        cnt    <= cnt - 8'd1;
`ifdef PARAM_CHECKSUM_EN
        csum   <= csum ^ i_data;
`endif
      end
      // Commit uses the pre-edge ch/fld/buffer even if a new command starts now.
      if (do_commit) begin
        for (int n = 0; n < NUM_OSC; n++) begin
          if (ch == 4'(n)) begin
            o_update[n] <= 1'b1;
            case (fld)
              3'd1:    o_wave[n*8 +: 8]           <= buffer[7:0];
              3'd2:    o_freq[n*FREQ_W +: FREQ_W]   <= buffer[FREQ_W-1:0];
              3'd3:    o_phase[n*PHASE_W +: PHASE_W] <= buffer[PHASE_W-1:0];
              3'd4:    o_amp[n*AMP_W +: AMP_W]     <= buffer[AMP_W-1:0];
              default: o_update[n] <= 1'b1;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_osc_param_ctrl.sv
// Directed, table-driven bench for osc_param_ctrl (default build, or checksum build
// when PARAM_CHECKSUM_EN is defined).
module tb_osc_param_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        data_valid;
  logic        busy;
  logic [15:0] wave;
  logic [47:0] freq;
  logic [31:0] phase;
  logic [31:0] amp;
  logic [1:0]  update;
  logic        cmd_err;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  osc_param_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(data_valid),
    .o_busy(busy), .o_wave(wave), .o_freq(freq), .o_phase(phase), .o_amp(amp),
    .o_update(update), .o_cmd_err(cmd_err), .o_timeout(timeout)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        busy;
    logic [1:0]  upd;
    logic        err;
    logic [47:0] freq;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    data = b;
    data_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    data = 8'h00;
    data_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h02, 1'b1, 2'b00, 1'b0, 48'h0};
    tbl[1]  = '{1'b1, 8'h12, 1'b1, 2'b00, 1'b0, 48'h0};
    tbl[2]  = '{1'b1, 8'h34, 1'b1, 2'b00, 1'b0, 48'h0};
    tbl[3]  = '{1'b1, 8'h56, 1'b1, 2'b00, 1'b0, 48'h0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 48'h000000_123456};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 48'h000000_123456};
    tbl[6]  = '{1'b1, 8'h25, 1'b0, 2'b00, 1'b1, 48'h000000_123456};
    tbl[7]  = '{1'b1, 8'h07, 1'b0, 2'b00, 1'b1, 48'h000000_123456};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 48'h000000_123456};
    tbl[9]  = '{1'b1, 8'h00, 1'b0, 2'b00, 1'b1, 48'h000000_123456};
    tbl[10] = '{1'b0, 8'hAA, 1'b0, 2'b00, 1'b0, 48'h000000_123456};

    // Reset with a valid command held: nothing may be decoded.
    rst = 1'b1;
    data = 8'h01;
    data_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_params", 64'({wave, freq} | 64'(phase) | 64'(amp)), 64'h0);
    chk("rst_pulses", 64'({update, cmd_err, timeout}), 64'h0);
    rst = 1'b0;
    idle();
    chk("post_rst_busy", 64'(busy), 64'h0);

`ifndef PARAM_CHECKSUM_EN
    for (int i = 0; i < 11; i++) begin
      data_valid = tbl[i].v;
      data = tbl[i].d;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d_upd", i), 64'(update), 64'(tbl[i].upd));
      chk($sformatf("tbl%0d_err", i), 64'(cmd_err), 64'(tbl[i].err));
      chk($sformatf("tbl%0d_freq", i), 64'(freq), 64'(tbl[i].freq));
    end
    chk("tbl_other_fields", 64'(wave) | 64'(phase) | 64'(amp), 64'h0);

    // Phase frame, then a new command accepted in the commit cycle.
    put(8'h13);
    put(8'hAB);
    put(8'hCD);
    put(8'h11);
    chk("b2b_upd1", 64'(update), 64'h2);
    chk("b2b_phase", 64'(phase), 64'hABCD_0000);
    chk("b2b_busy", 64'(busy), 64'h1);
    put(8'h05);
    chk("b2b_gap", 64'(update), 64'h0);
    idle();
    chk("b2b_upd2", 64'(update), 64'h2);
    chk("b2b_wave", 64'(wave), 64'h0500);

    // Inter-byte timeout after 1000 idle cycles.
    begin
      int k;
      put(8'h04);
      put(8'h80);
      k = 0;
      for (int n = 1; n <= 1100; n++) begin
        idle();
        if (timeout === 1'b1) begin
          k = n;
          break;
        end
      end
      chk("timeout_cycles", 64'(k), 64'd1000);
      chk("timeout_no_err", 64'(cmd_err), 64'h0);
      chk("timeout_amp", 64'(amp), 64'h0);
      chk("timeout_upd", 64'(update), 64'h0);
      idle();
      chk("timeout_busy", 64'(busy), 64'h0);
      chk("timeout_pulse", 64'(timeout), 64'h0);
    end
    put(8'h01);
    put(8'h03);
    idle();
    chk("after_to_upd", 64'(update), 64'h1);
    chk("after_to_wave", 64'(wave), 64'h0503);

    // Reset in the middle of a frame drops it; next byte is a command.
    put(8'h02);
    put(8'h99);
    rst = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_freq", 64'(freq), 64'h0);
    rst = 1'b0;
    put(8'h05);
    chk("midrst_err", 64'(cmd_err), 64'h1);
    chk("midrst_idle", 64'(busy), 64'h0);
`else
    put(8'h01);
    put(8'h07);
    chk("cs_busy_check", 64'(busy), 64'h1);
    put(8'h06);
    chk("cs_noupd_yet", 64'(update), 64'h0);
    idle();
    chk("cs_good_upd", 64'(update), 64'h1);
    chk("cs_good_wave", 64'(wave), 64'h0007);
    put(8'h01);
    put(8'h07);
    put(8'h00);
    chk("cs_bad_err", 64'(cmd_err), 64'h1);
    chk("cs_bad_busy", 64'(busy), 64'h0);
    idle();
    chk("cs_bad_upd", 64'(update), 64'h0);
    chk("cs_bad_wave", 64'(wave), 64'h0007);
    chk("cs_err_once", 64'(cmd_err), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
